uart_tx_stream: RTL and testbench

Parametrised single-clock UART transmit path: an internal synchronous FIFO accepts words from the fabric and a framing engine serialises them onto the line with configurable data width, parity and stop bits. It is the next-generation TX path of the DDR3-over-UART design. It adds the following over the current TX chain:

- back-to-back frames with no idle gap
- CTS-style pause input
- sticky overflow flag
- fill-level reporting

---
 rtl/uart_tx_stream.sv | 199 +++++++++++++++++++
 tb/tb_uart_tx_stream.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_stream.sv
// uart_tx_stream: FIFO-buffered UART transmitter with pause input,
// sticky overflow, fill level reporting and gapless back-to-back frames.
module uart_tx_stream #(
   parameter int DATA_W          = 8,
   parameter int CLKS_PER_BIT    = 868,
   parameter int FIFO_DEPTH      = 16,
   parameter int ALMOST_FULL_LVL = 14,
   parameter int PARITY          = 0,
   parameter int STOP_BITS       = 1
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_wr_en,
   input  logic [DATA_W-1:0]             i_wr_data,
   input  logic                          i_tx_en,
   output logic                          o_full,
   output logic                          o_almost_full,
   output logic                          o_empty,
   output logic [$clog2(FIFO_DEPTH):0]   o_count,
   output logic                          o_overflow,
   output logic                          o_TX_uart,
   output logic                          o_TX_active,
   output logic                          o_TX_done
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(DATA_W + 1);
   localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BAUD_PRE = BW'(CLKS_PER_BIT - 2);
   localparam logic [IW-1:0] BIT_MAX  = IW'(DATA_W - 1);
   localparam logic          STOP_MAX = 1'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
   } state_t;

   logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
   logic [PW-1:0]     r_wptr, r_rptr;
   logic [CW-1:0]     r_count;
   logic              r_full, r_empty, r_af, r_ovf;

   state_t            r_state;
   logic [BW-1:0]     r_baud;
   logic [IW-1:0]     r_bit;
   logic [DATA_W-1:0] r_shift;
   logic              r_par, r_stop;
   logic              r_tx, r_active, r_done;

   logic              w_wr, w_pop, w_par;
   logic              w_baud_end, w_stop_end;
   logic [DATA_W-1:0] w_head;
   logic [CW-1:0]     w_count_nxt;

   assign w_wr       = i_wr_en & ~r_full;
   assign w_head     = r_mem[r_rptr];
   assign w_par      = (PARITY == 1) ? ~^w_head : ^w_head;
   assign w_baud_end = (r_baud == BAUD_MAX);
   assign w_stop_end = w_baud_end & (r_stop == STOP_MAX);
   // Pops happen only at frame boundaries: from idle or on the last stop cycle
   assign w_pop = ~r_empty & i_tx_en &
                  ((r_state == S_IDLE) | ((r_state == S_STOP) & w_stop_end));

   always_comb begin
      w_count_nxt = r_count;
      if (w_wr & ~w_pop)
         w_count_nxt = r_count + CW'(1);
      else if (~w_wr & w_pop)
         w_count_nxt = r_count - CW'(1);
   end

   always_ff @(posedge i_clk) begin
      if (w_wr)
         r_mem[r_wptr] <= i_wr_data;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
         r_af    <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_wr)
            r_wptr <= r_wptr + PW'(1);
         if (w_pop)
            r_rptr <= r_rptr + PW'(1);
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == CW'(FIFO_DEPTH));
         r_empty <= (w_count_nxt == '0);
         r_af    <= (w_count_nxt >= CW'(ALMOST_FULL_LVL));
         if (i_wr_en & r_full)
            r_ovf <= 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= S_IDLE;
         r_baud   <= '0;
         r_bit    <= '0;
         r_shift  <= '0;
         r_par    <= 1'b0;
         r_stop   <= 1'b0;
         r_tx     <= 1'b1;
         r_active <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_shift  <= w_head;
                  r_par    <= w_par;
                  r_bit    <= '0;
                  r_baud   <= '0;
                  r_stop   <= 1'b0;
                  r_tx     <= 1'b0;
                  r_active <= 1'b1;
                  r_state  <= S_START;
               end
            end
            S_START: begin
               if (w_baud_end) begin
                  r_baud  <= '0;
                  r_tx    <= r_shift[0];
                  r_state <= S_DATA;
               end else
                  r_baud <= r_baud + BW'(1);
            end
            S_DATA: begin
               if (w_baud_end) begin
                  r_baud <= '0;
                  if (r_bit == BIT_MAX) begin
                     if (PARITY != 0) begin
                        r_tx    <= r_par;
                        r_state <= S_PARITY;
                     end else begin
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                     end
                  end else begin
                     r_bit   <= r_bit + IW'(1);
                     r_shift <= r_shift >> 1;
                     r_tx    <= r_shift[1];
                  end
               end else
                  r_baud <= r_baud + BW'(1);
            end
            S_PARITY: begin
               if (w_baud_end) begin
                  r_baud  <= '0;
                  r_tx    <= 1'b1;
                  r_state <= S_STOP;
               end else
                  r_baud <= r_baud + BW'(1);
            end
            S_STOP: begin
               if (w_baud_end) begin
                  r_baud <= '0;
                  if (!w_stop_end)
                     r_stop <= r_stop + 1'b1;
                  else if (w_pop) begin
                     r_shift <= w_head;
                     r_par   <= w_par;
                     r_bit   <= '0;
                     r_stop  <= 1'b0;
                     r_tx    <= 1'b0;
                     r_state <= S_START;
                  end else begin
                     r_tx     <= 1'b1;
                     r_active <= 1'b0;
                     r_state  <= S_IDLE;
                  end
               end else begin
                  r_baud <= r_baud + BW'(1);
                  if (r_baud == BAUD_PRE && r_stop == STOP_MAX)
                     r_done <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_full        = r_full;
   assign o_almost_full = r_af;
   assign o_empty       = r_empty;
   assign o_count       = r_count;
   assign o_overflow    = r_ovf;
   assign o_TX_uart     = r_tx;
   assign o_TX_active   = r_active;
   assign o_TX_done     = r_done;

endmodule

// File: tb/tb_uart_tx_stream.sv
// Bench for uart_tx_stream: three framings (8N1, 8E1, 8O2) share one
// stimulus; a line monitor decodes frames against a scoreboard.
module tb_uart_tx_stream;

   typedef struct packed {
      logic [7:0] d;
      logic       ep;
   } sb_t;

   typedef struct packed {
      logic [7:0] d;
      logic       acc;
      logic [2:0] cnt;
      logic       af;
      logic       full;
      logic       ovf;
   } ov_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       tx_en;
   logic [2:0] tx, act, dn, full, af, emp, ovf;
   logic [2:0] cnt [3];

   int   nerr = 0;
   int   nchk = 0;
   int   cyc = 0;
   int   t0 = 0;
   sb_t  sbq [3][$];
   int   dq  [3][$];

   logic        mbusy [3];
   int          mcnt  [3];
   logic [11:0] mbits [3];
   logic        mearly[3];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_stream #(.DATA_W(8), .CLKS_PER_BIT(4), .FIFO_DEPTH(4),
      .ALMOST_FULL_LVL(3), .PARITY(0), .STOP_BITS(1)) u_n1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_data(wr_data),
      .i_tx_en(tx_en), .o_full(full[0]), .o_almost_full(af[0]),
      .o_empty(emp[0]), .o_count(cnt[0]), .o_overflow(ovf[0]),
      .o_TX_uart(tx[0]), .o_TX_active(act[0]), .o_TX_done(dn[0]));

   uart_tx_stream #(.DATA_W(8), .CLKS_PER_BIT(4), .FIFO_DEPTH(4),
      .ALMOST_FULL_LVL(3), .PARITY(2), .STOP_BITS(1)) u_e1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_data(wr_data),
      .i_tx_en(tx_en), .o_full(full[1]), .o_almost_full(af[1]),
      .o_empty(emp[1]), .o_count(cnt[1]), .o_overflow(ovf[1]),
      .o_TX_uart(tx[1]), .o_TX_active(act[1]), .o_TX_done(dn[1]));

   uart_tx_stream #(.DATA_W(8), .CLKS_PER_BIT(4), .FIFO_DEPTH(4),
      .ALMOST_FULL_LVL(3), .PARITY(1), .STOP_BITS(2)) u_o2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_data(wr_data),
      .i_tx_en(tx_en), .o_full(full[2]), .o_almost_full(af[2]),
      .o_empty(emp[2]), .o_count(cnt[2]), .o_overflow(ovf[2]),
      .o_TX_uart(tx[2]), .o_TX_active(act[2]), .o_TX_done(dn[2]));

   function automatic int flen(int i);
      return (i == 0) ? 10 : (i == 1) ? 11 : 12;
   endfunction

   function automatic logic [11:0] exp_frame(int i, logic [7:0] d, logic ep);
      logic [11:0] f;
      f = '1;
      f[0] = 1'b0;
      f[8:1] = d;
      if (i == 1) f[9] = ep;
      if (i == 2) f[9] = ~ep;
      return f;
   endfunction

   task automatic chk(input string nm, input int a, input int e);
      nchk++;
      if (a != e) begin
         nerr++;
         $display("FAIL %s: actual=%0h required=%0h t=%0t", nm, a, e, $time);
      end
   endtask

   // Line monitor: decodes each frame mid-bit and checks it
   always @(negedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) mbusy[i] = 1'b0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (dn[i]) dq[i].push_back(cyc - t0);
            if (!mbusy[i] && !tx[i]) begin
               mbusy[i]  = 1'b1;
               mcnt[i]   = 0;
               mbits[i]  = '1;
               mearly[i] = 1'b0;
            end
            if (mbusy[i]) begin
               if (mcnt[i] % 4 == 2) mbits[i][mcnt[i] / 4] = tx[i];
               if (mcnt[i] == 4 * flen(i) - 1) begin
                  chk($sformatf("done_end%0d", i), {mearly[i], dn[i]}, 2'b01);
                  if (sbq[i].size() == 0) begin
                     nchk++;
                     nerr++;
                     $display("FAIL frame%0d unexpected: actual=%0h required=none",
                              i, mbits[i]);
                  end else begin
                     sb_t e;
                     e = sbq[i].pop_front();
                     chk($sformatf("frame%0d", i), mbits[i], exp_frame(i, e.d, e.ep));
                  end
                  mbusy[i] = 1'b0;
               end else begin
                  if (dn[i]) mearly[i] = 1'b1;
                  mcnt[i]++;
               end
            end
         end
      end
   end

   task automatic wr(input logic [7:0] d, input logic ep);
      sb_t s;
      s.d = d;
      s.ep = ep;
      wr_en = 1'b1;
      wr_data = d;
      for (int i = 0; i < 3; i++) sbq[i].push_back(s);
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic wait_idle(input int maxc);
      bit ok;
      ok = 1'b0;
      @(negedge clk);
      @(negedge clk);
      for (int n = 0; n < maxc; n++) begin
         if (act == 3'b000 && emp == 3'b111) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("idle_wait", ok, 1);
   endtask

   task automatic clr_dq();
      for (int i = 0; i < 3; i++) dq[i].delete();
   endtask

   sb_t pv [8];
   ov_t ov [5];
   logic [7:0] a5;
   int   e_tx, e_act, e_dn;

   initial begin
      #2000000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      pv[0] = '{8'h07, 1'b1}; pv[1] = '{8'hA5, 1'b0};
      pv[2] = '{8'h00, 1'b0}; pv[3] = '{8'hFF, 1'b0};
      pv[4] = '{8'h01, 1'b1}; pv[5] = '{8'h80, 1'b1};
      pv[6] = '{8'h3C, 1'b0}; pv[7] = '{8'h7F, 1'b1};
      ov[0] = '{8'h3C, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0};
      ov[1] = '{8'h5A, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0};
      ov[2] = '{8'h96, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0};
      ov[3] = '{8'hC3, 1'b1, 3'd4, 1'b1, 1'b1, 1'b0};
      ov[4] = '{8'hFF, 1'b0, 3'd4, 1'b1, 1'b1, 1'b1};
      a5 = 8'hA5;

      rst_n = 1'b1; wr_en = 1'b0; wr_data = '0; tx_en = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      for (int i = 0; i < 3; i++)
         chk($sformatf("reset%0d", i),
             {tx[i], act[i], dn[i], emp[i], full[i], af[i], ovf[i], cnt[i]},
             {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0});
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 0xA5 cycle-exact on 8N1, done timing on all framings
      clr_dq();
      t0 = cyc;
      wr(8'hA5, 1'b0);
      for (int k = 1; k <= 45; k++) begin
         e_tx  = (k < 2 || k > 37) ? 1 : (k <= 5) ? 0 : int'(a5[(k - 6) / 4]);
         e_act = (k >= 2 && k <= 41) ? 1 : 0;
         e_dn  = (k == 41) ? 1 : 0;
         chk($sformatf("a5_cyc%0d", k), {tx[0], act[0], dn[0]},
             {e_tx[0], e_act[0], e_dn[0]});
         if (k == 1) chk("a5_count", cnt[0], 1);
         @(negedge clk);
      end
      wait_idle(100);
      for (int i = 0; i < 3; i++)
         chk($sformatf("a5_done%0d", i),
             (dq[i].size() == 1) ? dq[i][0] : -1, 1 + 4 * flen(i));

      // Parity vectors
      for (int j = 0; j < 8; j++) begin
         wr(pv[j].d, pv[j].ep);
         wait_idle(200);
      end

      // Back-to-back
      clr_dq();
      t0 = cyc;
      wr(8'h11, ^8'h11);
      wr(8'h22, ^8'h22);
      wr(8'h33, ^8'h33);
      wait_idle(600);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("b2b_n%0d", i), dq[i].size(), 3);
         if (dq[i].size() == 3)
            for (int k = 0; k < 3; k++)
               chk($sformatf("b2b_done%0d_%0d", i, k), dq[i][k],
                   1 + (k + 1) * 4 * flen(i));
      end

      // Overflow / almost-full with transmission paused
      tx_en = 1'b0;
      for (int j = 0; j < 5; j++) begin
         sb_t s;
         s.d = ov[j].d;
         s.ep = ^ov[j].d;
         wr_en = 1'b1;
         wr_data = ov[j].d;
         if (ov[j].acc)
            for (int i = 0; i < 3; i++) sbq[i].push_back(s);
         @(negedge clk);
         wr_en = 1'b0;
         chk($sformatf("ovf_tbl%0d", j), {cnt[0], af[0], full[0], ovf[0]},
             {ov[j].cnt, ov[j].af, ov[j].full, ov[j].ovf});
         chk($sformatf("ovf_tbl_bc%0d", j), {cnt[1], ovf[1], cnt[2], ovf[2]},
             {ov[j].cnt, ov[j].ovf, ov[j].cnt, ov[j].ovf});
      end
      tx_en = 1'b1;
      wait_idle(800);
      chk("ovf_sticky", ovf, 3'b111);
      chk("ovf_drained", sbq[0].size() + sbq[1].size() + sbq[2].size(), 0);

      // Pause mid-frame with two words queued
      t0 = cyc;
      wr(8'h12, ^8'h12);
      wr(8'h34, ^8'h34);
      wr(8'h56, ^8'h56);
      repeat (7) @(negedge clk);
      tx_en = 1'b0;
      repeat (60) @(negedge clk);
      chk("pause_line", {tx, act}, {3'b111, 3'b000});
      chk("pause_count", {cnt[0], cnt[1], cnt[2]}, {3'd2, 3'd2, 3'd2});
      tx_en = 1'b1;
      chk("resume_pre", tx, 3'b111);
      @(negedge clk);
      chk("resume_start", tx, 3'b000);
      wait_idle(600);

      // Asynchronous reset in the middle of a start bit
      wr(8'h99, ^8'h99);
      repeat (2) @(negedge clk);
      chk("pre_reset", {tx, ovf}, {3'b000, 3'b111});
      #2 rst_n = 1'b0;
      #1;
      chk("mid_reset", {tx, act, emp, ovf, full},
          {3'b111, 3'b000, 3'b111, 3'b000, 3'b000});
      chk("mid_reset_cnt", {cnt[0], cnt[1], cnt[2]}, 9'd0);
      for (int i = 0; i < 3; i++) sbq[i].delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      wr(8'h5A, ^8'h5A);
      wait_idle(200);
      chk("final_drain", sbq[0].size() + sbq[1].size() + sbq[2].size(), 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
